// File: rtl/cipher_lock_pkg.sv
// Shared types and constants for the cipher lock controller and its timer.
package cipher_lock_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] KEY_CLEAR     = 4'hC;
  localparam logic [DIGIT_W-1:0] KEY_MAX_DIGIT = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_LOCKED,
    ST_VERIFY,
    ST_OPEN,
    ST_ALARM
  } state_e;

  function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
    return code <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the alarm lockout and the auto-relock window.
module lock_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] value_q, value_d;
  logic             expired_q, expired_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (value_q != '0) begin
      value_d = value_q - WIDTH'(1);
    end
    expired_d = (value_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q   <= '0;
      expired_q <= 1'b1;
    end else begin
      value_q   <= value_d;
      expired_q <= expired_d;
    end
  end

  assign value   = value_q;
  assign expired = expired_q;

endmodule

// File: rtl/cipher_lock_ctrl.sv
// Keypad cipher lock: password set/verify, failure counting, timed lockout and
// optional auto-relock. All status outputs are registered.
module cipher_lock_ctrl
  import cipher_lock_pkg::*;
#(
  parameter int unsigned PWD_LEN            = 4,
  parameter int unsigned MAX_FAIL           = 3,
  parameter int unsigned LOCKOUT_CYCLES     = 100000000,
  parameter int unsigned AUTO_RELOCK_CYCLES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         encrypt,
  input  logic                         decrypt,
  input  logic                         ascertain,
  input  logic                         key_valid,
  input  logic [DIGIT_W-1:0]           key_code,
  output logic                         locked,
  output logic                         unlocked,
  output logic                         alarm,
  output logic [2:0]                   fail_times,
  output logic [MAX_FAIL-1:0]          fail_therm,
  output logic [3:0]                   entry_count,
  output logic [DIGIT_W*PWD_LEN-1:0]   entry_digits
);

  localparam int unsigned ENTRY_W      = DIGIT_W * PWD_LEN;
  localparam int unsigned TIMER_MAX    = (LOCKOUT_CYCLES > AUTO_RELOCK_CYCLES) ?
                                         LOCKOUT_CYCLES : AUTO_RELOCK_CYCLES;
  localparam int unsigned TIMER_W      = $clog2(TIMER_MAX + 1);
  localparam int unsigned LOCKOUT_LOAD = LOCKOUT_CYCLES - 1;
  localparam int unsigned RELOCK_LOAD  = (AUTO_RELOCK_CYCLES == 0) ? 0 : AUTO_RELOCK_CYCLES - 1;
  localparam bit          RELOCK_EN    = (AUTO_RELOCK_CYCLES != 0);

  state_e               state_q, state_d;
  logic [ENTRY_W-1:0]   pwd_q, pwd_d;
  logic [ENTRY_W-1:0]   buf_q, buf_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           fail_q, fail_d;
  logic                 locked_q, locked_d;
  logic                 unlocked_q, unlocked_d;
  logic                 alarm_q, alarm_d;
  logic [MAX_FAIL-1:0]  therm_q, therm_d;

  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_load_value;
  logic [TIMER_W-1:0]   timer_value;
  logic                 timer_expired;

  logic                 any_cmd;
  logic                 entry_full;
  logic                 entry_en;
  logic [2:0]           fail_inc;

  assign any_cmd    = encrypt | decrypt | ascertain;
  assign entry_full = (cnt_q == 4'(PWD_LEN));
  assign fail_inc   = fail_q + 3'd1;

  lock_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .load_value(timer_load_value),
    .value     (timer_value),
    .expired   (timer_expired)
  );

  // Next state; a command pulse (even one ignored in this state) masks key_valid.
  always_comb begin
    state_d          = state_q;
    pwd_d            = pwd_q;
    buf_d            = buf_q;
    cnt_d            = cnt_q;
    fail_d           = fail_q;
    timer_load       = 1'b0;
    timer_load_value = '0;
    entry_en         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!ascertain && encrypt) begin
          state_d = ST_SET;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SET: begin
        if (ascertain) begin
          if (entry_full) begin
            pwd_d   = buf_q;
            buf_d   = '0;
            cnt_d   = '0;
            fail_d  = '0;
            state_d = ST_LOCKED;
          end
        end else if (!any_cmd) begin
          entry_en = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!ascertain && !encrypt && decrypt) begin
          state_d = ST_VERIFY;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_VERIFY: begin
        if (ascertain) begin
          buf_d = '0;
          cnt_d = '0;
          if (entry_full && (buf_q == pwd_q)) begin
            state_d = ST_OPEN;
            fail_d  = '0;
            if (RELOCK_EN) begin
              timer_load       = 1'b1;
              timer_load_value = TIMER_W'(RELOCK_LOAD);
            end
          end else begin
            fail_d = fail_inc;
            if (fail_inc == 3'(MAX_FAIL)) begin
              state_d          = ST_ALARM;
              timer_load       = 1'b1;
              timer_load_value = TIMER_W'(LOCKOUT_LOAD);
            end else begin
              state_d = ST_LOCKED;
            end
          end
        end else if (!any_cmd) begin
          entry_en = 1'b1;
        end
      end
      ST_OPEN: begin
        if (ascertain) begin
          state_d = ST_LOCKED;
        end else if (encrypt) begin
          state_d = ST_SET;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (RELOCK_EN) begin
          // Any activity restarts the relock window.
          if (decrypt || key_valid) begin
            timer_load       = 1'b1;
            timer_load_value = TIMER_W'(RELOCK_LOAD);
          end else if (timer_value == '0) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_ALARM: begin
        if (timer_expired) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (entry_en && key_valid) begin
      if (key_code == KEY_CLEAR) begin
        buf_d = '0;
        cnt_d = '0;
      end else if (is_digit(key_code) && !entry_full) begin
        buf_d = (buf_q << DIGIT_W) | ENTRY_W'(key_code);
        cnt_d = cnt_q + 4'd1;
      end
    end

    locked_d   = (state_d == ST_LOCKED) || (state_d == ST_VERIFY) || (state_d == ST_ALARM);
    unlocked_d = (state_d == ST_OPEN);
    alarm_d    = (state_d == ST_ALARM);
    therm_d    = '0;
    for (int unsigned i = 0; i < MAX_FAIL; i++) begin
      therm_d[i] = (fail_d > 3'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pwd_q      <= '0;
      buf_q      <= '0;
      cnt_q      <= '0;
      fail_q     <= '0;
      locked_q   <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      therm_q    <= '0;
    end else begin
      state_q    <= state_d;
      pwd_q      <= pwd_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      locked_q   <= locked_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
      therm_q    <= therm_d;
    end
  end

  assign locked       = locked_q;
  assign unlocked     = unlocked_q;
  assign alarm        = alarm_q;
  assign fail_times   = fail_q;
  assign fail_therm   = therm_q;
  assign entry_count  = cnt_q;
  assign entry_digits = buf_q;

endmodule
